arm_mmio_bus: RTL and testbench
===============================

ARM_MMIO_BUS -- requirements
Module: arm_mmio_bus

Interface
REQ-001 Parameter RAM_WORDS, default 64; number of 32-bit data RAM words (power of 2, max 64).
REQ-002 Parameter PRESCALE, default 50000; clk cycles per timer tick (>=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 MemWrite  input  1  store strobe from core, one cycle per store.
REQ-006 Addr  input  32  byte address (core ALU result); Addr[1:0] ignored.
REQ-007 WriteData  input  32  store data.
REQ-008 ReadData  output  32  load data, combinational from Addr and current state.
REQ-009 Switches  input  10  asynchronous board switches.
REQ-010 LEDs  output  10  LED register contents.
REQ-011 HexDigits  output  24  six 4-bit 7-segment digit codes.
REQ-012 TimerIRQ  output  1  equals the timer expired flag.

Function
REQ-013 Address map, decoded on Addr[11:0] with Addr[31:12]==0:
- 0x000-0x0FF RAM (word index Addr[7:2], masked to RAM_WORDS)
- 0x400 LEDS (R/W, bits 9:0)
- 0x404 SW (RO, bits 9:0)
- 0x408 TCTRL (R/W, bit0 EN, bit1 AUTO)
- 0x40C TLOAD (R/W, 32 bits)
- 0x410 TCOUNT (RO)
- 0x414 TSTAT (bit0 EXP, write-1-to-clear)
- 0x418 HEX (R/W, bits 23:0)
REQ-014 Unmapped addresses: ReadData=0; writes ignored; no state change.
REQ-015 Reads SHALL have zero latency (same cycle as Addr), so a single-cycle core can consume them.
REQ-016 Writes take effect at the clk edge where MemWrite=1; a read of the same address in the next cycle returns the new value.
REQ-017 Unused register bits read 0; writes to RO registers ignored.
REQ-018 Switches pass through a 2-flop synchronizer; SW reflects a change 2 cycles after it.
REQ-019 Prescaler counts 0..PRESCALE-1 while EN=1, emits a 1-cycle tick at PRESCALE-1 and wraps to 0; held at 0 while EN=0.
REQ-020 Writing TLOAD also loads TCOUNT with WriteData and clears the prescaler.
REQ-021 On a tick with TCOUNT>0: TCOUNT decrements by 1.
REQ-022 On a tick with TCOUNT==1 (transition to 0): EXP set; if AUTO=1, TCOUNT reloads TLOAD instead of reaching 0; if AUTO=0, TCOUNT=0 and EN cleared.
REQ-023 On a tick with TCOUNT==0: no change; EXP is not set again.
REQ-024 Writing TCTRL with EN 0->1 clears the prescaler; EN 1->0 freezes TCOUNT.
REQ-025 TSTAT write with bit0=1 clears EXP; if EXP is set by hardware in the same cycle, set wins.
REQ-026 TLOAD write and a tick in the same cycle: load wins, no decrement.
REQ-027 RAM: 32-bit word writes only; no byte enables; contents not reset.

Reset
REQ-028 On reset: LEDs=0, HEX=0, EN=0, AUTO=0, TLOAD=0, TCOUNT=0, prescaler=0, EXP=0, TimerIRQ=0, synchronizer flops=0.
REQ-029 Reset has priority over MemWrite in the same cycle; RAM contents preserved across reset.

Verification
REQ-030 Write 0xDEADBEEF to 0x014, then read 0x014 -> 0xDEADBEEF; read 0x018 unaffected; write 0x1000 -> every register and RAM word unchanged, read 0x1000 -> 0.
REQ-031 Write 0x3FF to 0x400 -> LEDs=0x3FF next cycle; read 0x400 -> 0x000003FF; Switches=0x155 -> SW reads 0x155 exactly 2 cycles later.
REQ-032 PRESCALE=4, TLOAD=3, TCTRL=0x1 -> TCOUNT 3,2,1,0 at 4-cycle spacing; EXP/TimerIRQ=1 on reaching 0; EN reads 0; no further change.
REQ-033 PRESCALE=4, TLOAD=2, TCTRL=0x3 -> TCOUNT 2,1,2,1,... with EXP set at each reload; write TSTAT=1 clears EXP; a same-cycle expiry keeps EXP=1.
REQ-034 Timer running with LEDs=0x0AA, reset asserted for 1 cycle -> all registers 0, TimerIRQ=0, and a previously written RAM word still reads its value.

Source files
------------

// File: rtl/arm_mmio_bus.sv
// Memory-mapped bus for a single-cycle ARM-style core: word RAM, LED/switch/hex I/O
// and a prescaled down-counting timer with expiry flag. Reads are combinational.
module arm_mmio_bus #(
    parameter int unsigned RAM_WORDS = 64,
    parameter int unsigned PRESCALE  = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic [9:0]  Switches,
    output logic [9:0]  LEDs,
    output logic [23:0] HexDigits,
    output logic        TimerIRQ
);

    localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int unsigned PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LEDS,
        SEL_SW,
        SEL_TCTRL,
        SEL_TLOAD,
        SEL_TCOUNT,
        SEL_TSTAT,
        SEL_HEX
    } sel_e;

    sel_e              sel;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       ram [RAM_WORDS];

    logic [9:0]      leds_q,   leds_d;
    logic [23:0]     hex_q,    hex_d;
    logic            en_q,     en_d;
    logic            auto_q,   auto_d;
    logic [31:0]     tload_q,  tload_d;
    logic [31:0]     tcount_q, tcount_d;
    logic [PS_W-1:0] presc_q,  presc_d;
    logic            exp_q,    exp_d;
    logic [9:0]      sw_meta_q, sw_sync_q;

    logic tick;
    logic exp_set;
    logic wr_ram, wr_leds, wr_tctrl, wr_tload, wr_tstat, wr_hex;

    // Anything outside the low 4 KiB, or in the gaps of the map, decodes to SEL_NONE.
    always_comb begin
        sel = SEL_NONE;
        if (Addr[31:12] == '0) begin
            if (Addr[11:8] == 4'h0) begin
                sel = SEL_RAM;
            end else begin
                case (Addr[11:2])
                    10'h100: sel = SEL_LEDS;
                    10'h101: sel = SEL_SW;
                    10'h102: sel = SEL_TCTRL;
                    10'h103: sel = SEL_TLOAD;
                    10'h104: sel = SEL_TCOUNT;
                    10'h105: sel = SEL_TSTAT;
                    10'h106: sel = SEL_HEX;
                    default: sel = SEL_NONE;
                endcase
            end
        end
    end

    assign ram_idx  = RAM_AW'(Addr[7:2] & 6'(RAM_WORDS - 1));

    assign wr_ram   = MemWrite && (sel == SEL_RAM);
    assign wr_leds  = MemWrite && (sel == SEL_LEDS);
    assign wr_tctrl = MemWrite && (sel == SEL_TCTRL);
    assign wr_tload = MemWrite && (sel == SEL_TLOAD);
    assign wr_tstat = MemWrite && (sel == SEL_TSTAT);
    assign wr_hex   = MemWrite && (sel == SEL_HEX);

    // RAM contents deliberately survive reset; only the write strobe is gated.
    always_ff @(posedge clk) begin
        if (!reset && wr_ram) begin
            ram[ram_idx] <= WriteData;
        end
    end

    assign tick = en_q && (presc_q == PS_MAX);

    always_comb begin
        leds_d   = leds_q;
        hex_d    = hex_q;
        en_d     = en_q;
        auto_d   = auto_q;
        tload_d  = tload_q;
        tcount_d = tcount_q;
        presc_d  = presc_q;
        exp_d    = exp_q;
        exp_set  = 1'b0;

        if (wr_leds) leds_d = WriteData[9:0];
        if (wr_hex)  hex_d  = WriteData[23:0];

        if (en_q) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        // A TLOAD write in the same cycle consumes the tick entirely.
        if (tick && (tcount_q != '0) && !wr_tload) begin
            if (tcount_q == 32'd1) begin
                exp_set = 1'b1;
                if (auto_q) begin
                    tcount_d = tload_q;
                end else begin
                    tcount_d = '0;
                    en_d     = 1'b0;
                end
            end else begin
                tcount_d = tcount_q - 32'd1;
            end
        end

        if (wr_tstat && WriteData[0]) exp_d = 1'b0;
        if (exp_set)                  exp_d = 1'b1;

        if (wr_tctrl) begin
            en_d   = WriteData[0];
            auto_d = WriteData[1];
            if (WriteData[0] && !en_q) presc_d = '0;
        end

        if (wr_tload) begin
            tload_d  = WriteData;
            tcount_d = WriteData;
            presc_d  = '0;
        end

        if (!en_d) presc_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            leds_q    <= '0;
            hex_q     <= '0;
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            tload_q   <= '0;
            tcount_q  <= '0;
            presc_q   <= '0;
            exp_q     <= 1'b0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            leds_q    <= leds_d;
            hex_q     <= hex_d;
            en_q      <= en_d;
            auto_q    <= auto_d;
            tload_q   <= tload_d;
            tcount_q  <= tcount_d;
            presc_q   <= presc_d;
            exp_q     <= exp_d;
            sw_meta_q <= Switches;
            sw_sync_q <= sw_meta_q;
        end
    end

    always_comb begin
        ReadData = '0;
        case (sel)
            SEL_RAM:    ReadData = ram[ram_idx];
            SEL_LEDS:   ReadData = {22'd0, leds_q};
            SEL_SW:     ReadData = {22'd0, sw_sync_q};
            SEL_TCTRL:  ReadData = {30'd0, auto_q, en_q};
            SEL_TLOAD:  ReadData = tload_q;
            SEL_TCOUNT: ReadData = tcount_q;
            SEL_TSTAT:  ReadData = {31'd0, exp_q};
            SEL_HEX:    ReadData = {8'd0, hex_q};
            default:    ReadData = '0;
        endcase
    end

    assign LEDs      = leds_q;
    assign HexDigits = hex_q;
    assign TimerIRQ  = exp_q;

endmodule

// File: tb/tb_arm_mmio_bus.sv
// Directed bench for arm_mmio_bus: vector table for the address map plus
// hand-written timer, synchronizer and reset sequences (PRESCALE=4).
module tb_arm_mmio_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [9:0]  Switches;
    logic [9:0]  LEDs;
    logic [23:0] HexDigits;
    logic        TimerIRQ;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    arm_mmio_bus #(.RAM_WORDS(64), .PRESCALE(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Switches  (Switches),
        .LEDs      (LEDs),
        .HexDigits (HexDigits),
        .TimerIRQ  (TimerIRQ)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;   // write data, or expected read data
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one bus cycle and advance past the clock edge.
    task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d);
        MemWrite  = we;
        Addr      = a;
        WriteData = d;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        MemWrite = 1'b0;
        Addr     = a;
        #1;
        check(name, ReadData, exp);
    endtask

    initial begin
        reset = 1'b1; MemWrite = 1'b0; Addr = '0; WriteData = '0; Switches = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        tbl.push_back('{1'b0, 32'h400, 32'h0,        "rst_leds"});
        tbl.push_back('{1'b0, 32'h408, 32'h0,        "rst_tctrl"});
        tbl.push_back('{1'b0, 32'h40C, 32'h0,        "rst_tload"});
        tbl.push_back('{1'b0, 32'h410, 32'h0,        "rst_tcount"});
        tbl.push_back('{1'b0, 32'h414, 32'h0,        "rst_tstat"});
        tbl.push_back('{1'b0, 32'h418, 32'h0,        "rst_hex"});
        tbl.push_back('{1'b1, 32'h018, 32'h12345678, "w018"});
        tbl.push_back('{1'b1, 32'h014, 32'hDEADBEEF, "w014"});
        tbl.push_back('{1'b0, 32'h014, 32'hDEADBEEF, "ram014"});
        tbl.push_back('{1'b0, 32'h017, 32'hDEADBEEF, "ram014_lowbits"});
        tbl.push_back('{1'b0, 32'h018, 32'h12345678, "ram018_kept"});
        tbl.push_back('{1'b1, 32'h1000, 32'hFFFFFFFF, "w1000"});
        tbl.push_back('{1'b1, 32'h1014, 32'h0BADF00D, "w1014"});
        tbl.push_back('{1'b1, 32'h114, 32'h0BADF00D,  "w114"});
        tbl.push_back('{1'b1, 32'h41C, 32'hFFFFFFFF,  "w41c"});
        tbl.push_back('{1'b0, 32'h1000, 32'h0,        "rd_unmapped_hi"});
        tbl.push_back('{1'b0, 32'h114, 32'h0,         "rd_unmapped_gap"});
        tbl.push_back('{1'b0, 32'h014, 32'hDEADBEEF,  "ram014_after_unmapped"});
        tbl.push_back('{1'b0, 32'h000, 32'hxxxxxxxx,  ""});
        tbl.push_back('{1'b0, 32'h400, 32'h0,         "leds_after_unmapped"});
        tbl.push_back('{1'b0, 32'h418, 32'h0,         "hex_after_unmapped"});
        tbl.push_back('{1'b1, 32'h0FC, 32'hA5A5A5A5,  "w0fc"});
        tbl.push_back('{1'b0, 32'h0FC, 32'hA5A5A5A5,  "ram_top"});
        tbl.push_back('{1'b1, 32'h400, 32'h000003FF,  "wleds"});
        tbl.push_back('{1'b0, 32'h400, 32'h000003FF,  "leds3ff"});
        tbl.push_back('{1'b1, 32'h400, 32'hFFFFFC00,  "wleds_hi"});
        tbl.push_back('{1'b0, 32'h400, 32'h0,         "leds_unused_bits"});
        tbl.push_back('{1'b1, 32'h418, 32'hFFABCDEF,  "whex"});
        tbl.push_back('{1'b0, 32'h418, 32'h00ABCDEF,  "hex_mask"});
        tbl.push_back('{1'b1, 32'h408, 32'hFFFFFFFE,  "wtctrl_auto"});
        tbl.push_back('{1'b0, 32'h408, 32'h2,         "tctrl_auto"});
        tbl.push_back('{1'b1, 32'h408, 32'h0,         "wtctrl0"});
        tbl.push_back('{1'b0, 32'h408, 32'h0,         "tctrl0"});
        tbl.push_back('{1'b1, 32'h404, 32'h3FF,       "wsw_ro"});
        tbl.push_back('{1'b0, 32'h404, 32'h0,         "sw_ro"});
        tbl.push_back('{1'b1, 32'h410, 32'h5,         "wtcount_ro"});
        tbl.push_back('{1'b0, 32'h410, 32'h0,         "tcount_ro"});

        foreach (tbl[i]) begin
            if (tbl[i].name == "") continue;
            if (tbl[i].we) cyc(1'b1, tbl[i].addr, tbl[i].data);
            else           rd(tbl[i].name, tbl[i].addr, tbl[i].data);
        end

        // LED / HEX output ports follow their registers one edge after the write.
        cyc(1'b1, 32'h400, 32'h0AA);
        check("leds_port", {22'd0, LEDs}, 32'h0AA);
        cyc(1'b1, 32'h418, 32'h123456);
        check("hex_port", {8'd0, HexDigits}, 32'h123456);

        // Switch synchronizer: two edges of latency.
        Switches = 10'h155;
        rd("sw_0cyc", 32'h404, 32'h0);
        cyc(1'b0, 32'h404, 32'h0);
        rd("sw_1cyc", 32'h404, 32'h0);
        cyc(1'b0, 32'h404, 32'h0);
        rd("sw_2cyc", 32'h404, 32'h155);

        // One-shot: TLOAD=3, EN=1; ticks every 4 edges after enable.
        cyc(1'b1, 32'h40C, 32'd3);
        cyc(1'b1, 32'h408, 32'h1);
        for (int k = 0; k <= 16; k++) begin
            int unsigned e;
            e = (k / 4 >= 3) ? 0 : 3 - k / 4;
            rd($sformatf("oneshot_cnt_k%0d", k), 32'h410, e);
            check($sformatf("oneshot_irq_k%0d", k), {31'd0, TimerIRQ}, (k >= 12) ? 32'd1 : 32'd0);
            cyc(1'b0, 32'h410, 32'h0);
        end
        rd("oneshot_en_cleared", 32'h408, 32'h0);
        rd("oneshot_exp", 32'h414, 32'h1);
        rd("oneshot_cnt_held", 32'h410, 32'h0);

        // Auto-reload: TLOAD=2, EN|AUTO.
        cyc(1'b1, 32'h414, 32'h1);
        rd("tstat_w1c", 32'h414, 32'h0);
        cyc(1'b1, 32'h40C, 32'd2);
        cyc(1'b1, 32'h408, 32'h3);
        for (int k = 0; k <= 9; k++) begin
            rd($sformatf("auto_cnt_k%0d", k), 32'h410, ((k / 4) % 2 == 0) ? 32'd2 : 32'd1);
            check($sformatf("auto_irq_k%0d", k), {31'd0, TimerIRQ}, (k >= 8) ? 32'd1 : 32'd0);
            cyc(1'b0, 32'h410, 32'h0);
        end
        cyc(1'b1, 32'h414, 32'h1);                        // k=10 -> 11
        check("auto_w1c_irq", {31'd0, TimerIRQ}, 32'd0);
        rd("auto_cnt_k11", 32'h410, 32'd2);
        repeat (4) cyc(1'b0, 32'h410, 32'h0);             // k=15
        cyc(1'b1, 32'h414, 32'h1);                        // clear and expire together
        check("auto_set_wins", {31'd0, TimerIRQ}, 32'd1);
        rd("auto_cnt_k16", 32'h410, 32'd2);
        repeat (3) cyc(1'b0, 32'h410, 32'h0);             // k=19, tick pending
        cyc(1'b1, 32'h40C, 32'd7);
        rd("load_beats_tick", 32'h410, 32'd7);
        repeat (3) cyc(1'b0, 32'h410, 32'h0);
        rd("load_presc_cleared", 32'h410, 32'd7);
        cyc(1'b0, 32'h410, 32'h0);
        rd("load_then_tick", 32'h410, 32'd6);

        // Reset while running, with a competing LED write.
        reset = 1'b1;
        cyc(1'b1, 32'h400, 32'h3FF);
        reset = 1'b0;
        check("rst2_leds_port", {22'd0, LEDs}, 32'h0);
        check("rst2_hex_port", {8'd0, HexDigits}, 32'h0);
        check("rst2_irq", {31'd0, TimerIRQ}, 32'h0);
        rd("rst2_tctrl", 32'h408, 32'h0);
        rd("rst2_tload", 32'h40C, 32'h0);
        rd("rst2_tcount", 32'h410, 32'h0);
        rd("rst2_tstat", 32'h414, 32'h0);
        rd("rst2_sw_sync", 32'h404, 32'h0);
        rd("rst2_ram_kept", 32'h014, 32'hDEADBEEF);
        repeat (6) cyc(1'b0, 32'h410, 32'h0);
        rd("rst2_timer_idle", 32'h410, 32'h0);
        rd("rst2_sw_resync", 32'h404, 32'h155);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
